keypad_scanner: RTL and testbench

Drives the columns of a 4x4 matrix keypad, samples the rows, debounces the result and emits a stable 4-bit key code where 4'hF means "no key". It sits directly upstream of the key-detection stage, which turns that code into a data-available flag, and it is the only block that touches the keypad pins.

---
 rtl/keypad_scanner_pkg.sv | 21 ++
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_scanner_sync2.sv | 29 ++
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: matrix geometry,
// the "no key" code, the controller state type and the key encoder.
package keypad_pkg;

  localparam logic [3:0] NO_KEY  = 4'hF;
  localparam int         KP_ROWS = 4;
  localparam int         KP_COLS = 4;

  // SETTLE only follows reset; SCAN is the normal operating state.
  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    SCAN   = 1'b1
  } scan_state_e;

  // Key code is row*4+col; with 2-bit fields this is a plain concatenation.
  function automatic logic [3:0] encode_key(input logic [1:0] row,
                                            input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side and key-side signals of the keypad scanner. The master modport is
// the scanner itself; the slave modport is the keypad / downstream side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KP_ROWS-1:0] row_i;
  logic [KP_COLS-1:0] col_o;
  logic [3:0]         key_pressed_o;
  logic               key_strobe_o;

  modport master (
    input  row_i,
    output col_o,
    output key_pressed_o,
    output key_strobe_o
  );

  modport slave (
    output row_i,
    input  col_o,
    input  key_pressed_o,
    input  key_strobe_o
  );

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchronizer for asynchronous pin inputs. The reset value
// is a parameter so idle pulled-up pins can come out of reset as all ones.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, samples the
// synchronized rows late in each column slot, reduces each full scan to a
// single key code (ghosting and multi-press give NO_KEY) and debounces that
// code over several identical scans before updating the registered output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic [KP_ROWS-1:0] row_s;

  scan_state_e   state_q,      state_d;
  logic [DW-1:0] div_cnt_q,    div_cnt_d;
  logic [1:0]    col_idx_q,    col_idx_d;
  logic [1:0]    hit_cnt_q,    hit_cnt_d;
  logic [3:0]    hit_code_q,   hit_code_d;
  logic [3:0]    candidate_q,  candidate_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [3:0]    key_q,        key_d;
  logic          strobe_q,     strobe_d;

  logic          sample;
  logic [2:0]    col_hits;
  logic [2:0]    hit_sum;
  logic [1:0]    base_hits;
  logic [3:0]    base_code;
  logic [1:0]    last_row;
  logic          row_seen;
  logic [3:0]    scan_result;

  sync2 #(
    .WIDTH     (KP_ROWS),
    .RESET_VAL ({KP_ROWS{1'b1}})
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.row_i),
    .q_o (row_s)
  );

  // State register for sequencer, accumulator, debouncer and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SETTLE;
      div_cnt_q    <= '0;
      col_idx_q    <= 2'd0;
      hit_cnt_q    <= 2'd0;
      hit_code_q   <= NO_KEY;
      candidate_q  <= NO_KEY;
      stable_cnt_q <= '0;
      key_q        <= NO_KEY;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      col_idx_q    <= col_idx_d;
      hit_cnt_q    <= hit_cnt_d;
      hit_code_q   <= hit_code_d;
      candidate_q  <= candidate_d;
      stable_cnt_q <= stable_cnt_d;
      key_q        <= key_d;
      strobe_q     <= strobe_d;
    end
  end

  // Next-state logic: column timing, per-scan hit accumulation, scan
  // reduction and debounce all resolve on the same sample edge.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    col_idx_d    = col_idx_q;
    hit_cnt_d    = hit_cnt_q;
    hit_code_d   = hit_code_q;
    candidate_d  = candidate_q;
    stable_cnt_d = stable_cnt_q;
    key_d        = key_q;
    strobe_d     = 1'b0;
    col_hits     = 3'd0;
    hit_sum      = 3'd0;
    base_hits    = 2'd0;
    base_code    = NO_KEY;
    last_row     = 2'd0;
    row_seen     = 1'b0;
    scan_result  = NO_KEY;

    sample = (div_cnt_q == DIV_LAST);

    for (int r = 0; r < KP_ROWS; r++) begin
      if (!row_s[r]) begin
        col_hits = col_hits + 3'd1;
        last_row = 2'(r);
        row_seen = 1'b1;
      end
    end

    if (sample) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end

    case (state_q)
      SETTLE: begin
        if (sample) begin
          state_d   = SCAN;
          col_idx_d = 2'd0;
        end
      end

      SCAN: begin
        if (sample) begin
          col_idx_d = col_idx_q + 2'd1;

          if (col_idx_q != 2'd0) begin
            base_hits = hit_cnt_q;
            base_code = hit_code_q;
          end

          hit_sum    = {1'b0, base_hits} + col_hits;
          hit_cnt_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
          hit_code_d = row_seen ? encode_key(last_row, col_idx_q) : base_code;

          if (col_idx_q == 2'd3) begin
            scan_result = (hit_cnt_d == 2'd1) ? hit_code_d : NO_KEY;

            if (scan_result != candidate_q) begin
              candidate_d  = scan_result;
              stable_cnt_d = SW'(1);
            end else if (stable_cnt_q < STABLE_MAX) begin
              stable_cnt_d = stable_cnt_q + SW'(1);
            end

            if ((stable_cnt_d == STABLE_MAX) && (candidate_d != key_q)) begin
              key_d    = candidate_d;
              strobe_d = (candidate_d != NO_KEY);
            end
          end
        end
      end

      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  assign kp.col_o         = ~(KP_COLS'(1) << col_idx_q);
  assign kp.key_pressed_o = key_q;
  assign kp.key_strobe_o  = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised scoreboard bench for keypad_scanner. A keypad matrix model
// pulls rows low for pressed keys in the driven column; a scan-level
// reference model predicts every output change and its cycle.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_LEN = 4 * SCAN_DIV;

  typedef struct {
    logic [3:0]  code;
    logic        strobe;
    int unsigned cycle;
  } exp_event_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keyMask = 16'h0000;
  logic [3:0]  rowDrive;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned gcyc = 0;
  int unsigned edgeCnt = 0;
  int unsigned scansDone = 0;

  exp_event_t  expQ[$];
  logic [3:0]  history[$];
  logic [3:0]  modelOut = NO_KEY;

  keypad_scanner_if kpIf();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kpIf)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key connects its row to its column line.
  always_comb begin
    rowDrive = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keyMask[r*4+c] && !kpIf.col_o[c]) rowDrive[r] = 1'b0;
      end
    end
  end

  assign kpIf.row_i = rowDrive;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, gcyc);
    end
  endtask

  // Whole-scan view: exactly one pressed key gives its index, else no key.
  function automatic logic [3:0] scanOutcome(input logic [15:0] m);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (m[i]) idx = i;
    return ($countones(m) == 1) ? 4'(idx) : NO_KEY;
  endfunction

  function automatic logic [3:0] expCol(input int unsigned k);
    logic [3:0] one = 4'b0001;
    int unsigned idx;
    if (k < SCAN_DIV) return 4'b1110;
    idx = ((k - SCAN_DIV) / SCAN_DIV) % 4;
    return ~(one << idx);
  endfunction

  // Reference model: settle slot, then a scan verdict every SCAN_LEN edges;
  // output follows once the last DEB verdicts agree on a new value.
  initial begin
    logic [3:0] res;
    bit         allSame;
    forever begin
      @(posedge clk);
      gcyc++;
      if (rst) begin
        edgeCnt = 0;
        history.delete();
        if (modelOut != NO_KEY) expQ.push_back('{NO_KEY, 1'b0, gcyc});
        modelOut = NO_KEY;
      end else begin
        edgeCnt++;
        if (edgeCnt >= 5 * SCAN_DIV && ((edgeCnt - SCAN_DIV) % SCAN_LEN) == 0) begin
          res = scanOutcome(keyMask);
          history.push_back(res);
          scansDone++;
          if (history.size() >= DEB) begin
            allSame = 1'b1;
            for (int j = 0; j < DEB; j++)
              if (history[history.size()-1-j] != res) allSame = 1'b0;
            if (allSame && res != modelOut) begin
              modelOut = res;
              expQ.push_back('{res, (res != NO_KEY), gcyc});
            end
          end
        end
      end
    end
  end

  // Monitor: checks the column pattern every cycle and pops the scoreboard
  // whenever the key output changes or the strobe fires.
  initial begin
    logic [3:0] prevKey = NO_KEY;
    logic       prevStrobe = 1'b0;
    exp_event_t e;
    forever begin
      @(negedge clk);
      checkOutput("col_o", {28'h0, kpIf.col_o}, {28'h0, expCol(edgeCnt)});
      if (kpIf.key_pressed_o !== prevKey || kpIf.key_strobe_o !== 1'b0) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_event: got key %0h strobe %0b, expected no change (cycle %0d)",
                   kpIf.key_pressed_o, kpIf.key_strobe_o, gcyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("key_pressed_o", {28'h0, kpIf.key_pressed_o}, {28'h0, e.code});
          checkOutput("key_strobe_o", {31'h0, kpIf.key_strobe_o}, {31'h0, e.strobe});
          checkOutput("event_cycle", gcyc, e.cycle);
        end
      end
      while (expQ.size() > 0 && expQ[0].cycle < gcyc) begin
        e = expQ.pop_front();
        vectors++;
        miscompares++;
        $display("[TB] FAIL missed_event: got key %0h, expected key %0h strobe %0b at cycle %0d",
                 kpIf.key_pressed_o, e.code, e.strobe, e.cycle);
      end
      if (kpIf.key_strobe_o === 1'b1)
        checkOutput("strobe_spacing", {31'h0, prevStrobe}, 32'h0);
      prevKey    = kpIf.key_pressed_o;
      prevStrobe = kpIf.key_strobe_o;
    end
  end

  // Hold a key mask from a scan boundary for nScans complete scans.
  task automatic applyStimulus(input logic [15:0] mask, input int nScans);
    int unsigned target = scansDone + nScans;
    int unsigned guard = 0;
    keyMask = mask;
    while (scansDone < target && guard < nScans * SCAN_LEN * 2 + 100) begin
      @(negedge clk);
      guard++;
    end
    if (scansDone < target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scan_timeout: got %0d scans, expected %0d", scansDone, target);
    end
  endtask

  initial begin
    int kind, hold, a, b;
    $display("[TB] keypad_scanner bench start");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_key", {28'h0, kpIf.key_pressed_o}, {28'h0, NO_KEY});
    checkOutput("reset_strobe", {31'h0, kpIf.key_strobe_o}, 32'h0);
    checkOutput("reset_col", {28'h0, kpIf.col_o}, 32'h0000000E);
    rst = 1'b0;

    applyStimulus(16'h0000, 3);
    applyStimulus(16'h0040, 6);
    applyStimulus(16'h0000, 4);

    for (int i = 0; i < 10; i++)
      applyStimulus((i % 2 == 0) ? 16'h0040 : 16'h0000, 1);
    applyStimulus(16'h0000, 4);

    applyStimulus(16'h0201, 5);
    applyStimulus(16'h0001, 5);
    applyStimulus(16'h0000, 4);

    applyStimulus(16'h0040, 5);
    applyStimulus(16'h0200, 5);
    applyStimulus(16'h0000, 5);

    applyStimulus(16'h0020, 2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midscan_reset_key", {28'h0, kpIf.key_pressed_o}, {28'h0, NO_KEY});
    checkOutput("midscan_reset_strobe", {31'h0, kpIf.key_strobe_o}, 32'h0);
    applyStimulus(16'h0020, 5);
    applyStimulus(16'h0000, 4);

    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 5);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (kind)
        0: applyStimulus(16'h0000, hold);
        1: applyStimulus(16'h0001 << a, hold);
        2: applyStimulus((16'h0001 << a) | (16'h0001 << b), hold);
        default: begin
          for (int k = 0; k < hold + 1; k++)
            applyStimulus((k % 2 == 0) ? (16'h0001 << a) : 16'h0000, 1);
        end
      endcase
    end

    applyStimulus(16'h0000, DEB + 2);
    repeat (2) @(negedge clk);
    checkOutput("pending_events", expQ.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
